// File: rtl/fp_mc_pkg.sv
// fp_mc_pkg: shared definitions for the FPU multi-cycle sequencer.
//   - op encodings (sqrt / div)
//   - sequencer state encoding
//   - RISC-V fflags bit positions within {NV,DZ,OF,UF,NX}
//   - canonical quiet NaN constants for 32- and 64-bit operands
package fp_mc_pkg;

    localparam logic OP_SQRT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } fp_mc_state_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_64 = 64'h7FF8_0000_0000_0000;

    // Canonical NaN for the given operand width, right-aligned in 64 bits.
    function automatic logic [63:0] canon_nan(input int flen);
        if (flen == 64) begin
            return CANON_NAN_64;
        end
        return {32'h0, CANON_NAN_32};
    endfunction

endpackage

// File: rtl/fp_mc_sequencer_watchdog.sv
// fp_mc_watchdog: cycle counter with limit compare for the sequencer's
// WAIT/DRAIN states. Only instantiated when FP_MC_TIMEOUT_EN is defined.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   clear        - zero the counter (asserted whenever not counting, and on
//                  the WAIT->DRAIN transition so DRAIN starts a fresh budget)
//   tick         - count this cycle (sequencer is in WAIT or DRAIN)
//   expired      - LIMIT cycles have elapsed in the current counting window
module fp_mc_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The LIMIT-th counting cycle is the one that fires, so an op that never
    // completes leaves WAIT after exactly LIMIT cycles there.
    assign expired = tick && !clear && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fp_mc_sequencer.sv
// fp_mc_sequencer: initiator side of the FPU multi-cycle start/done handshake.
// Accepts one FSQRT/FDIV request, pulses start to the selected unit, holds
// operands/rm on the shared unit bus until that unit's done, and returns the
// result + fflags on a valid/ready response port. One op in flight at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. rsp_valid, once high, stays high with stable payload until
// the transfer (or a flush, which has priority and drops the response).
//
// Ports:
//   clk, reset                   - clock, asynchronous active-high reset
//   flush                        - kill pending/in-flight op
//   req_*                        - request port (op, rm, a, b, tag)
//   sqrt_start, div_start        - one-cycle start pulses
//   unit_rm, unit_a, unit_b      - latched operands, shared by both units
//   sqrt_done/result/nv/nx       - sqrt unit completion
//   div_done/result/flags        - div unit completion
//   rsp_*                        - response port (result, tag, fflags)
//   busy                         - sequencer not idle (for hazard/stall logic)
//   state_dbg                    - current FSM state
// Optional build macro: FP_MC_TIMEOUT_EN adds a WAIT/DRAIN watchdog that
// answers with canonical NaN / NV after TIMEOUT_CYCLES.
module fp_mc_sequencer
    import fp_mc_pkg::*;
#(
    parameter int FLEN           = 32,
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [2:0]       req_rm,
    input  logic [FLEN-1:0]  req_a,
    input  logic [FLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             sqrt_start,
    output logic             div_start,
    output logic [2:0]       unit_rm,
    output logic [FLEN-1:0]  unit_a,
    output logic [FLEN-1:0]  unit_b,
    input  logic             sqrt_done,
    input  logic [FLEN-1:0]  sqrt_result,
    input  logic             sqrt_nv,
    input  logic             sqrt_nx,
    input  logic             div_done,
    input  logic [FLEN-1:0]  div_result,
    input  logic [4:0]       div_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [FLEN-1:0]  rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [4:0]       rsp_fflags,
    output logic             busy,
    output fp_mc_state_e     state_dbg
);
    fp_mc_state_e     state_q, state_d;
    logic             op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    logic [FLEN-1:0]  a_q, a_d;
    logic [FLEN-1:0]  b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [FLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    logic [4:0]       ff_q, ff_d;

    logic             done_sel;
    logic [4:0]       sqrt_ff;

    // Only the unit that was started may complete the op.
    assign done_sel = (op_q == OP_DIV) ? div_done : sqrt_done;

    always_comb begin
        sqrt_ff        = '0;
        sqrt_ff[FF_NV] = sqrt_nv;
        sqrt_ff[FF_NX] = sqrt_nx;
    end

`ifdef FP_MC_TIMEOUT_EN
    localparam logic [63:0] CANON_NAN_FULL = canon_nan(FLEN);

    logic wd_clear, wd_tick, wd_expired;

    assign wd_tick  = (state_q == WAIT) || (state_q == DRAIN);
    assign wd_clear = !wd_tick || ((state_q == WAIT) && flush);

    fp_mc_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rm_d       = rm_q;
        a_d        = a_q;
        b_d        = b_q;
        tag_d      = tag_q;
        res_d      = res_q;
        rtag_d     = rtag_q;
        ff_d       = ff_q;
        sqrt_start = 1'b0;
        div_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    rm_d    = req_rm;
                    a_d     = req_a;
                    b_d     = req_b;
                    tag_d   = req_tag;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Start is combinational so a same-cycle flush can suppress it.
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    sqrt_start = (op_q == OP_SQRT);
                    div_start  = (op_q == OP_DIV);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    // A unit that completes in the flush cycle has nothing
                    // left to drain.
                    state_d = done_sel ? IDLE : DRAIN;
                end else if (done_sel) begin
                    res_d   = (op_q == OP_DIV) ? div_result : sqrt_result;
                    ff_d    = (op_q == OP_DIV) ? div_flags : sqrt_ff;
                    rtag_d  = tag_q;
                    state_d = RESP;
                end
`ifdef FP_MC_TIMEOUT_EN
                else if (wd_expired) begin
                    res_d        = CANON_NAN_FULL[FLEN-1:0];
                    ff_d         = '0;
                    ff_d[FF_NV]  = 1'b1;
                    rtag_d       = tag_q;
                    state_d      = RESP;
                end
`endif
            end
            DRAIN: begin
                if (done_sel) begin
                    state_d = IDLE;
                end
`ifdef FP_MC_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = IDLE;
                end
`endif
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_SQRT;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            rtag_q  <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rm_q    <= rm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            rtag_q  <= rtag_d;
            ff_q    <= ff_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !flush;
    assign unit_rm    = rm_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = res_q;
    assign rsp_tag    = rtag_q;
    assign rsp_fflags = ff_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: doc/fp_mc_sequencer.md
Name: fp_mc_sequencer

Overview:
Initiator side of the FPU's multi-cycle start/done handshake. It accepts one FSQRT or FDIV request from the FP execute stage and latches the operands. It then pulses start to the selected multi-cycle unit (sqrt or div), holds the operands and rounding mode stable until that unit's done pulse, and returns the result plus RISC-V fflags on a valid/ready response port. It serialises the units (one op in flight), handles pipeline flush, and drives busy for the hazard/stall logic.

Parameters:
FLEN, 32, operand width (32 or 64)
TAG_W, 5, width of destination tag carried through (rd index)
TIMEOUT_CYCLES, 64, watchdog limit in WAIT/DRAIN (used only with FP_MC_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset; one clock; reset is asynchronous and active-high
flush  in  1  kill in-flight/pending op
req_valid  in  1  request valid
req_ready  out  1  request accept; = (state==IDLE) && !flush
req_op  in  1  0 = sqrt, 1 = div
req_rm  in  3  resolved rounding mode
req_a  in  FLEN  sqrt operand / dividend
req_b  in  FLEN  divisor (ignored for sqrt)
req_tag  in  TAG_W  destination tag
sqrt_start  out  1  one-cycle start pulse to sqrt unit
div_start  out  1  one-cycle start pulse to div unit
unit_rm  out  3  latched rounding mode, shared bus
unit_a  out  FLEN  latched operand a, shared bus
unit_b  out  FLEN  latched operand b, shared bus
sqrt_done  in  1  sqrt completion pulse
sqrt_result  in  FLEN  sqrt result, valid with sqrt_done
sqrt_nv  in  1  sqrt invalid flag, valid with sqrt_done
sqrt_nx  in  1  sqrt inexact flag, valid with sqrt_done
div_done  in  1  div completion pulse
div_result  in  FLEN  div result, valid with div_done
div_flags  in  5  div fflags {NV,DZ,OF,UF,NX}, valid with div_done
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_result  out  FLEN  result
rsp_tag  out  TAG_W  tag
rsp_fflags  out  5  {NV,DZ,OF,UF,NX}
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all registered outputs 0 (starts, unit_rm/a/b, rsp_valid/result/tag/fflags, busy).
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: on req_valid && req_ready, latch op, rm, a, b, tag → ISSUE.
- ISSUE: assert the selected start (sqrt_start if op=0, else div_start) for exactly this cycle → WAIT.
- unit_a, unit_b and unit_rm are driven from the latches and held stable from ISSUE through the done cycle. The sqrt unit samples the operand after start and rm late in its ROUND stage.
- WAIT: only the selected unit's done counts; the other unit's done is ignored.
- On done, capture the result, tag and flags → RESP. Sqrt fflags = {sqrt_nv, 0, 0, 0, sqrt_nx}; div fflags = div_flags.
- RESP: rsp_valid=1; rsp_result, rsp_tag and rsp_fflags stay stable until rsp_ready, then → IDLE with rsp_valid=0 the next cycle.
- Latency: accept at T; start at T+1; done at T+N; rsp_valid at T+N+1. Back-to-back accept at the earliest one cycle after the response handshake.
- Flush handling:
  - IDLE: the request is not accepted.
  - ISSUE: the start pulse is suppressed → IDLE.
  - WAIT: → DRAIN (units cannot abort).
  - DRAIN: wait for the selected done, discard it → IDLE. req_ready stays 0 in DRAIN.
  - WAIT with done and flush in the same cycle: the result is discarded → IDLE.
  - RESP: the response is dropped (rsp_valid low next cycle) → IDLE.
  - Flush has priority over rsp_ready.
- Reset mid-op: immediate return to IDLE. The units share the same reset, so no drain is needed.

Optional Feature:
FP_MC_TIMEOUT_EN
- Defined: a watchdog counter clears on entry to WAIT/DRAIN and increments each cycle without done.
  - Reaching TIMEOUT_CYCLES in WAIT → RESP with canonical NaN (0x7FC00000 for FLEN=32, 0x7FF8000000000000 for FLEN=64) and fflags 5'b10000.
  - Reaching TIMEOUT_CYCLES in DRAIN → IDLE.
  - A late done after a timeout is ignored.
- Undefined: no counter; WAIT/DRAIN wait indefinitely.

Decomposition:
- fp_mc_pkg holds:
  - op encodings (OP_SQRT=0, OP_DIV=1)
  - state encodings
  - fflags bit indices
  - canonical-NaN constants per FLEN
- Sub-module fp_mc_watchdog: counter + limit compare, instantiated only under FP_MC_TIMEOUT_EN.

Test Plan:
- sqrt req_a=0x40800000 (4.0), rm=RNE, tag=7 → exactly one sqrt_start, no div_start; unit_a held through done; response 0x40000000, fflags 0, tag 7, latency N+1 from accept.
- div stub returns done with div_flags=5'b01000, result 0x7F800000 → rsp_fflags=5'b01000, rsp_result=0x7F800000; sqrt_done pulse injected mid-op is ignored.
- rsp_ready held low 3 cycles → rsp_valid/result/fflags stable; req_ready=0 throughout; accept succeeds one cycle after the handshake.
- flush in WAIT, then done 5 cycles later → no rsp_valid; busy stays 1 until the done cycle +1; the next sqrt request completes normally.
- flush in ISSUE → no start pulse, return to IDLE; flush in RESP → rsp_valid drops the next cycle; reset asserted mid-WAIT → all outputs 0 asynchronously.
- FP_MC_TIMEOUT_EN, TIMEOUT_CYCLES=8, stub never asserts done → rsp_result=0x7FC00000, fflags=5'b10000 after 8 WAIT cycles.
